// File: rtl/sub_op_flag_stage_if.sv
// Handshake bundle between the subtractor, the flag stage and writeback/branch logic.
// Master drives operands and consumes the head entry; slave is the flag stage itself.
interface sub_op_flag_stage_if #(
    parameter int unsigned OPERAND_WIDTH = 32,
    parameter int unsigned DEPTH         = 2
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic                     in_valid;
    logic                     in_ready;
    logic [OPERAND_WIDTH-1:0] lhs;
    logic [OPERAND_WIDTH-1:0] rhs;
    logic [OPERAND_WIDTH-1:0] result;
    logic                     out_valid;
    logic                     out_ready;
    logic [OPERAND_WIDTH-1:0] out_result;
    logic                     out_zero;
    logic                     out_negative;
    logic                     out_borrow;
    logic                     out_overflow;
    logic [CntW-1:0]          count;

    modport master (
        output in_valid, lhs, rhs, result, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_negative, out_borrow,
               out_overflow, count
    );

    modport slave (
        input  in_valid, lhs, rhs, result, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_negative, out_borrow,
               out_overflow, count
    );
endinterface

// File: rtl/sub_op_flag_stage.sv
// Registered stage after the subtractor: derives zero/negative/borrow/overflow at push time
// and queues result plus flags in a small FIFO behind a valid/ready handshake.
module sub_op_flag_stage #(
    parameter int unsigned OPERAND_WIDTH = 32,
    parameter int unsigned DEPTH         = 2
) (
    input logic                clk,
    input logic                rst,
    sub_op_flag_stage_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned W    = OPERAND_WIDTH;
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

    // Flag vector layout: {zero, negative, borrow, overflow}
    logic [W-1:0]    res_mem_q  [DEPTH];
    logic [3:0]      flag_mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;

    logic            push;
    logic            pop;
    logic [3:0]      in_flags;

    always_comb begin
        bus.in_ready  = (count_q < Full) && !rst;
        bus.out_valid = (count_q != '0);
        push          = bus.in_valid && bus.in_ready;
        pop           = bus.out_valid && bus.out_ready;

        // Borrow comes from the operands so a bogus result cannot mask it.
        in_flags[3] = (bus.result == '0);
        in_flags[2] = bus.result[W-1];
        in_flags[1] = (bus.lhs < bus.rhs);
        in_flags[0] = (bus.lhs[W-1] != bus.rhs[W-1]) && (bus.result[W-1] != bus.lhs[W-1]);

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                res_mem_q[i]  <= '0;
                flag_mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                res_mem_q[wr_ptr_q]  <= bus.result;
                flag_mem_q[wr_ptr_q] <= in_flags;
                wr_ptr_q             <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Head is read straight from storage; stale when empty.
    always_comb begin
        bus.out_result   = res_mem_q[rd_ptr_q];
        bus.out_zero     = flag_mem_q[rd_ptr_q][3];
        bus.out_negative = flag_mem_q[rd_ptr_q][2];
        bus.out_borrow   = flag_mem_q[rd_ptr_q][1];
        bus.out_overflow = flag_mem_q[rd_ptr_q][0];
        bus.count        = count_q;
    end
endmodule

// File: tb/tb_sub_op_flag_stage.sv
// Directed bench for sub_op_flag_stage (W=8, DEPTH=2): stimulus queues hand-computed
// expectations, a monitor pops and compares on every accepted output.
module tb_sub_op_flag_stage;
    localparam int unsigned W = 8;
    localparam int unsigned D = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sub_op_flag_stage_if #(.OPERAND_WIDTH(W), .DEPTH(D)) bus ();

    sub_op_flag_stage #(.OPERAND_WIDTH(W), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Expected entry: {result, zero, negative, borrow, overflow}
    logic [W+3:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares the head entry whenever it is consumed.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got 0x%0h expected no entry", bus.out_result);
            end else begin
                logic [W+3:0] e;
                e = exp_q.pop_front();
                check("pop_result", 32'(bus.out_result), 32'(e[W+3:4]));
                check("pop_flags", 32'({bus.out_zero, bus.out_negative, bus.out_borrow,
                                        bus.out_overflow}), 32'(e[3:0]));
            end
        end
    end

    task automatic drive(input logic v, input logic [W-1:0] l, input logic [W-1:0] r,
                         input logic [W-1:0] res);
        bus.in_valid = v;
        bus.lhs      = l;
        bus.rhs      = r;
        bus.result   = res;
    endtask

    // Presents one triple until accepted (bounded), then queues its expectation.
    task automatic push(input logic [W-1:0] l, input logic [W-1:0] r, input logic [W-1:0] res,
                        input logic [3:0] flags);
        bit ok = 0;
        drive(1'b1, l, r, res);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got in_ready 0 expected 1");
        end else begin
            @(posedge clk);
            exp_q.push_back({res, flags});
        end
        #1;
        drive(1'b0, '0, '0, '0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] out_flags();
        return 32'({bus.out_zero, bus.out_negative, bus.out_borrow, bus.out_overflow});
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, '0, '0, '0);
        bus.out_ready = 1'b0;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_count", 32'(bus.count), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_out_result", 32'(bus.out_result), 0);
        check("rst_flags", out_flags(), 0);

        // Zero result, then pop
        @(posedge clk); #1;
        push(8'h05, 8'h05, 8'h00, 4'b1000);
        @(negedge clk);
        check("zero_out_valid", 32'(bus.out_valid), 1);
        check("zero_count", 32'(bus.count), 1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        idle(1);
        @(negedge clk);
        check("zero_popped_count", 32'(bus.count), 0);
        check("zero_popped_valid", 32'(bus.out_valid), 0);

        // Negative/borrow and signed overflow
        @(posedge clk); #1;
        push(8'h03, 8'h05, 8'hFE, 4'b0110);
        push(8'h80, 8'h01, 8'h7F, 4'b0001);
        idle(3);

        // Fill, refuse a third entry, drain in order
        bus.out_ready = 1'b0;
        push(8'h10, 8'h01, 8'h0F, 4'b0000);
        push(8'h20, 8'h01, 8'h1F, 4'b0000);
        @(negedge clk);
        check("full_count", 32'(bus.count), 2);
        check("full_in_ready", 32'(bus.in_ready), 0);
        check("full_out_result", 32'(bus.out_result), 32'h0F);
        @(posedge clk); #1;
        drive(1'b1, 8'h30, 8'h01, 8'h2F);
        idle(2);
        drive(1'b0, '0, '0, '0);
        @(negedge clk);
        check("full_reject_count", 32'(bus.count), 2);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        idle(2);
        @(negedge clk);
        check("drain_count", 32'(bus.count), 0);
        check("drain_in_ready", 32'(bus.in_ready), 1);

        // Simultaneous push and pop at count=1, pointers wrap several times
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        push(8'h40, 8'h01, 8'h3F, 4'b0000);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [W-1:0] l;
            l = 8'h60 + 8'(i);
            drive(1'b1, l, 8'h01, l - 8'h01);
            @(negedge clk);
            check("pp_count", 32'(bus.count), 1);
            check("pp_in_ready", 32'(bus.in_ready), 1);
            @(posedge clk);
            exp_q.push_back({l - 8'h01, 4'b0000});
            #1;
        end
        drive(1'b0, '0, '0, '0);
        idle(2);
        @(negedge clk);
        check("pp_drained", 32'(bus.count), 0);

        // Reset with two entries held and in_valid asserted
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        push(8'h03, 8'h05, 8'hFE, 4'b0110);
        push(8'h80, 8'h01, 8'h7F, 4'b0001);
        rst = 1'b1;
        exp_q.delete();
        drive(1'b1, 8'h11, 8'h01, 8'h10);
        @(negedge clk);
        check("rst_mid_in_ready", 32'(bus.in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, '0, '0, '0);
        @(negedge clk);
        check("rst_mid_count", 32'(bus.count), 0);
        check("rst_mid_out_valid", 32'(bus.out_valid), 0);
        check("rst_mid_out_result", 32'(bus.out_result), 0);
        check("rst_mid_flags", out_flags(), 0);
        idle(2);
        @(negedge clk);
        check("rst_mid_not_captured", 32'(bus.count), 0);

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
